gain_controller: RTL and testbench



---
 rtl/iagc_pkg.sv | 7 +
 rtl/gain_step_saturator.sv | 27 ++
 rtl/gain_controller.sv | 97 +++++++++
 tb/tb_gain_controller.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/iagc_pkg.sv
// iagc_pkg: shared IAGC status codes, gain FSM state encodings and step directions
package iagc_pkg;
    localparam logic [3:0] IAGC_STATUS_RESET = 4'b0000;
    localparam logic [3:0] IAGC_STATUS_INIT  = 4'b0001;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_COMPARE = 2'd1, ST_APPLY = 2'd2, ST_DONE = 2'd3} state_t;
    typedef enum logic [1:0] {DIR_HOLD = 2'd0, DIR_UP = 2'd1, DIR_DOWN = 2'd2} dir_t;
endpackage

// File: rtl/gain_step_saturator.sv
// gain_step_saturator: steps gain by +/-step per dir and clamps to [min_gain, max_gain]
// ports: gain, dir, step, min_gain, max_gain in; next_gain, clamped out (combinational)
module gain_step_saturator
    import iagc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] gain,
    input  dir_t         dir,
    input  logic [W-1:0] step,
    input  logic [W-1:0] min_gain,
    input  logic [W-1:0] max_gain,
    output logic [W-1:0] next_gain,
    output logic         clamped
);
    // two guard bits so gain+step never wraps even at full-scale gain
    logic signed [W+1:0] cand, lo, hi;
    always_comb begin
        lo = $signed({2'b00, min_gain});
        hi = $signed({2'b00, max_gain});
        cand = dir == DIR_UP   ? $signed({2'b00, gain}) + $signed({2'b00, step}) :
               dir == DIR_DOWN ? $signed({2'b00, gain}) - $signed({2'b00, step}) :
                                 $signed({2'b00, gain});
        clamped = cand < lo || cand > hi;
        next_gain = cand < lo ? min_gain : cand > hi ? max_gain : cand[W-1:0];
    end
endmodule

// File: rtl/gain_controller.sv
// gain_controller: closed-loop AGC gain stepping with deadband, saturation and lock detect
// ports: i_clock, i_reset (sync, active high), i_iagcStatus (RESET/INIT clear the loop),
//        i_referenceAmplitude/i_errorAmplitude/i_update from the amplitude detector;
//        o_gain, o_gainValid (one-cycle pulse), o_locked, o_saturated
module gain_controller
    import iagc_pkg::*;
#(
    parameter int IAGC_STATUS_SIZE    = 4,
    parameter int AMPLITUDE_DATA_SIZE = 16,
    parameter int GAIN_DATA_SIZE      = 16,
    parameter int GAIN_FRAC_BITS      = 12,
    parameter int GAIN_INIT           = 4096,
    parameter int GAIN_STEP           = 16,
    parameter int GAIN_MIN            = 0,
    parameter int GAIN_MAX            = 65535,
    parameter int DEADBAND            = 8,
    parameter int LOCK_COUNT          = 4
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic [IAGC_STATUS_SIZE-1:0]    i_iagcStatus,
    input  logic [AMPLITUDE_DATA_SIZE-1:0] i_referenceAmplitude,
    input  logic [AMPLITUDE_DATA_SIZE-1:0] i_errorAmplitude,
    input  logic                           i_update,
    output logic [GAIN_DATA_SIZE-1:0]      o_gain,
    output logic                           o_gainValid,
    output logic                           o_locked,
    output logic                           o_saturated
);
    localparam int A = AMPLITUDE_DATA_SIZE;
    localparam int G = GAIN_DATA_SIZE;
    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam logic signed [A:0] DB = (A+1)'(DEADBAND);
    localparam logic [LW-1:0] LOCK_Q = LW'(LOCK_COUNT);
    state_t state, state_nx;
    dir_t dir;
    logic [A-1:0] ref_q, err_q;
    logic [G-1:0] gain, gain_nx;
    logic [LW-1:0] lock_cnt;
    logic clamped, saturated, locked, clear;
    logic signed [A:0] diff;
    assign clear = i_reset || i_iagcStatus == IAGC_STATUS_SIZE'(IAGC_STATUS_RESET)
                           || i_iagcStatus == IAGC_STATUS_SIZE'(IAGC_STATUS_INIT);
    // one extra bit keeps ref-err exact over the full signed input range
    assign diff = $signed({ref_q[A-1], ref_q}) - $signed({err_q[A-1], err_q});
    gain_step_saturator #(.W(G)) u_sat (
        .gain      (gain),
        .dir       (dir),
        .step      (G'(GAIN_STEP)),
        .min_gain  (G'(GAIN_MIN)),
        .max_gain  (G'(GAIN_MAX)),
        .next_gain (gain_nx),
        .clamped   (clamped)
    );
    always_ff @(posedge i_clock) begin
        if (clear) begin
            state <= ST_IDLE;
            dir <= DIR_HOLD;
            ref_q <= '0;
            err_q <= '0;
            gain <= G'(GAIN_INIT);
            saturated <= 1'b0;
            lock_cnt <= '0;
            locked <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && i_update) begin
                ref_q <= i_referenceAmplitude;
                err_q <= i_errorAmplitude;
            end
            if (state == ST_COMPARE)
                dir <= diff > DB ? DIR_UP : diff < -DB ? DIR_DOWN : DIR_HOLD;
            if (state == ST_APPLY) begin
                if (dir != DIR_HOLD) begin
                    gain <= gain_nx;
                    saturated <= clamped;
                    lock_cnt <= '0;
                    locked <= 1'b0;
                end else if (lock_cnt != LOCK_Q) begin
                    lock_cnt <= lock_cnt + 1'b1;
                    locked <= lock_cnt + 1'b1 == LOCK_Q;
                end
            end
        end
    end
    always_comb begin
        state_nx = state == ST_IDLE    ? (i_update ? ST_COMPARE : ST_IDLE) :
                   state == ST_COMPARE ? ST_APPLY :
                   state == ST_APPLY   ? ST_DONE : ST_IDLE;
    end
    always_comb begin
        o_gain = gain;
        o_gainValid = state == ST_DONE;
        o_locked = locked;
        o_saturated = saturated;
    end
endmodule

// File: tb/tb_gain_controller.sv
// tb_gain_controller: directed self-checking bench for gain_controller (default and GAIN_MAX=4100)
module tb_gain_controller;
    logic        i_clock = 1'b0;
    logic        i_reset;
    logic [3:0]  i_iagcStatus;
    logic [15:0] i_referenceAmplitude, i_errorAmplitude;
    logic        i_update;
    logic [15:0] d_gain, s_gain;
    logic        d_valid, d_locked, d_sat, s_valid, s_locked, s_sat;
    int n_checks = 0;
    int n_fails = 0;
    int g_prev = 4096;
    int pulses;

    always #5 i_clock = ~i_clock;

    gain_controller d (
        .i_clock(i_clock), .i_reset(i_reset), .i_iagcStatus(i_iagcStatus),
        .i_referenceAmplitude(i_referenceAmplitude), .i_errorAmplitude(i_errorAmplitude),
        .i_update(i_update), .o_gain(d_gain), .o_gainValid(d_valid),
        .o_locked(d_locked), .o_saturated(d_sat)
    );

    gain_controller #(.GAIN_MAX(4100)) s (
        .i_clock(i_clock), .i_reset(i_reset), .i_iagcStatus(i_iagcStatus),
        .i_referenceAmplitude(i_referenceAmplitude), .i_errorAmplitude(i_errorAmplitude),
        .i_update(i_update), .o_gain(s_gain), .o_gainValid(s_valid),
        .o_locked(s_locked), .o_saturated(s_sat)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    // one update on the default instance; inputs are scrambled after the strobe to prove latching
    task automatic do_update(input int r, input int e, input int exp_gain,
                             input int exp_sat, input int exp_lock, input string tag);
        i_referenceAmplitude = 16'(r);
        i_errorAmplitude = 16'(e);
        i_update = 1'b1;
        tick();
        i_update = 1'b0;
        i_referenceAmplitude = 16'(e);
        i_errorAmplitude = 16'(r);
        tick();
        chk({tag, "_apply_gain"}, int'(d_gain), g_prev);
        chk({tag, "_apply_valid"}, int'(d_valid), 0);
        tick();
        chk({tag, "_gain"}, int'(d_gain), exp_gain);
        chk({tag, "_valid"}, int'(d_valid), 1);
        chk({tag, "_sat"}, int'(d_sat), exp_sat);
        chk({tag, "_lock"}, int'(d_locked), exp_lock);
        tick();
        chk({tag, "_valid_end"}, int'(d_valid), 0);
        g_prev = exp_gain;
    endtask

    initial begin
        i_reset = 1'b1;
        i_iagcStatus = 4'b0010;
        i_update = 1'b0;
        i_referenceAmplitude = '0;
        i_errorAmplitude = '0;
        repeat (2) tick();
        i_reset = 1'b0;
        chk("rst_gain", int'(d_gain), 4096);
        chk("rst_valid", int'(d_valid), 0);
        chk("rst_lock", int'(d_locked), 0);
        chk("rst_sat", int'(d_sat), 0);
        tick();
        chk("idle_valid", int'(d_valid), 0);

        do_update(1000, 900, 4112, 0, 0, "up");
        do_update(900, 1000, 4096, 0, 0, "down");

        for (int i = 0; i < 4; i++)
            do_update(1000, 1008, 4096, 0, (i == 3) ? 1 : 0, $sformatf("db%0d", i));
        do_update(1000, 1100, 4080, 0, 0, "unlock");

        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        i_referenceAmplitude = 16'd1000;
        i_errorAmplitude = 16'd0;
        i_update = 1'b1;
        pulses = 0;
        tick();
        pulses += int'(d_valid);
        tick();
        pulses += int'(d_valid);
        tick();
        i_update = 1'b0;
        pulses += int'(d_valid);
        for (int i = 0; i < 6; i++) begin
            tick();
            pulses += int'(d_valid);
        end
        chk("ign_pulses", pulses, 1);
        chk("ign_gain", int'(d_gain), 4112);
        g_prev = 4112;

        do_update(1000, 0, 4128, 0, 0, "ramp1");
        do_update(1000, 0, 4144, 0, 0, "ramp2");
        do_update(1000, 0, 4160, 0, 0, "ramp3");
        i_referenceAmplitude = 16'd1000;
        i_errorAmplitude = 16'd0;
        i_update = 1'b1;
        tick();
        i_update = 1'b0;
        tick();
        i_iagcStatus = 4'b0001;
        tick();
        chk("init_gain", int'(d_gain), 4096);
        chk("init_valid", int'(d_valid), 0);
        chk("init_lock", int'(d_locked), 0);
        i_iagcStatus = 4'b0010;
        tick();
        chk("init_valid2", int'(d_valid), 0);
        chk("init_gain2", int'(d_gain), 4096);
        g_prev = 4096;
        do_update(1000, 900, 4112, 0, 0, "post_init");

        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        g_prev = 4096;
        chk("sat_rst_gain", int'(s_gain), 4096);
        do_update(1000, 0, 4112, 0, 0, "sat_d1");
        chk("sat1_gain", int'(s_gain), 4100);
        chk("sat1_flag", int'(s_sat), 1);
        do_update(1000, 0, 4128, 0, 0, "sat_d2");
        chk("sat2_gain", int'(s_gain), 4100);
        chk("sat2_flag", int'(s_sat), 1);
        do_update(0, 1000, 4112, 0, 0, "sat_d3");
        chk("sat3_gain", int'(s_gain), 4084);
        chk("sat3_flag", int'(s_sat), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
